disp_scan_ctrl: RTL and testbench
=================================

Name: disp_scan_ctrl

Overview:
- Drives a 6-digit multiplexed 7-segment display showing HH:MM:SS.
- Time-shares one Clock_sep (0..99 to tens/units segment code) converter across the three fields, one digit slot at a time.
- Takes a snapshot of the time on a load strobe, so a frame never shows a mix of old and new values.
- Adds anti-ghost blanking between digits and field blinking for set mode. Sits between the timekeeping core and the board display pins.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYC, 2: cycles at the start of each slot during which DIG_SEL is held 0; must be < SCAN_DIV. A value of 0 means no blanking.
- BLINK_FRAMES, 64: number of full 6-digit frames per blink half-period; must be ≥ 1.

Ports:
- CLK  in  1: system clock.
- RST  in  1: synchronous, active-high reset.
- HOUR  in  7: hour value, 0..99 meaningful.
- MIN  in  7: minute value.
- SEC  in  7: second value.
- LOAD  in  1: capture HOUR/MIN/SEC into the snapshot on this edge.
- BLINK_SEL  in  2: 0 none, 1 hour, 2 minute, 3 second.
- SEG_DATA  out  8: segment code for the active digit (Number_to_code format).
- DIG_SEL  out  6: one-hot, active-high digit enable. Bit 5 = hour tens, bit 4 = hour units, bit 3 = min tens, bit 2 = min units, bit 1 = sec tens, bit 0 = sec units.
- FRAME_START  out  1: one-cycle pulse in the first cycle of each hour-tens slot.

Behaviour:
- Reset (RST high at an edge) sets: SEG_DATA=0, DIG_SEL=0, FRAME_START=0, snapshots=0, cnt=0, dig=5, fcnt=0, blink_phase=0, primed=0. RST has priority over all other inputs, including mid-slot.
- Snapshot: the snapshot registers update on the edge where LOAD=1. A slot already in progress keeps its registered SEG_DATA; the new values are used from the next slot.
- Slot counter cnt runs 0..SCAN_DIV-1. At the edge where cnt==SCAN_DIV-1 ("wrap"):
  - cnt<=0 and dig<=(dig==5)?0:dig+1.
  - SEG_DATA<=code(next dig), computed from the current snapshot.
  - DIG_SEL<=0 and primed<=1.
- Converter mux:
  - Field = next_dig>>1 (0 hour, 1 min, 2 sec); that snapshot value drives Clock_sep.NUMBER.
  - An even next_dig selects N10, an odd one selects N1.
  - A field value >99 displays as code(0) on both digits.
- Enable edge:
  - When BLANK_CYC>0, at the edge with cnt==BLANK_CYC-1: DIG_SEL<=onehot(dig), provided primed==1 and the digit is not blink-suppressed.
  - When BLANK_CYC==0, DIG_SEL loads at the wrap edge under the same condition.
  - DIG_SEL holds until the next wrap.
- Blink suppression: blink_phase==1 and BLINK_SEL!=0 and field(dig)==BLINK_SEL-1. BLINK_SEL is sampled at the enable edge.
- Frame: a wrap with dig==5→0 is a frame start.
  - FRAME_START<=1 for exactly the next cycle.
  - fcnt: if fcnt==BLINK_FRAMES-1 then fcnt<=0 and blink_phase toggles; otherwise fcnt+1.
- Latency:
  - SEG_DATA valid from the first cycle of a slot.
  - DIG_SEL high for SCAN_DIV-BLANK_CYC cycles per slot.
  - Frame period 6*SCAN_DIV.
- After reset the first slot (dig=5) is dead: DIG_SEL stays 0 for SCAN_DIV cycles. The first visible digit is hour tens.
- SEG_DATA and DIG_SEL are registered, with no combinational path from the inputs.

Decomposition:
- Shared package/header holds:
  - Digit index constants DIG_H10..DIG_S1 (0..5).
  - Field codes FLD_HOUR/MIN/SEC.
  - BLINK_SEL encodings.
- Exactly one Clock_sep instance inside, shared by all six digits. No other sub-module.
- Prescaler, digit sequencer, snapshot and blink logic stay in this module.

Test Plan (SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2):
- Reset, then LOAD with 12:34:56 → cycles 0-7 have DIG_SEL=0. Cycle 8 gives SEG=code(1) with DIG_SEL=0 for 2 cycles, then 6'b100000 for 6 cycles. The following slots give code(2)/010000, code(3)/001000, code(4)/000100, code(5)/000010, code(6)/000001, with a 48-cycle period.
- HOUR=100, MIN=7, SEC=0 → hour digits show code(0),code(0); minute digits show code(0),code(7); second digits show code(0),code(0).
- LOAD 23:48:07 during slot dig=3 → dig3 slot SEG unchanged (code(4) from 34). dig4 shows code(0), dig5 code(7); the next frame shows 2,3,4,8,0,7.
- BLINK_SEL=2 → DIG_SEL[3:2] stays 0 throughout frames with blink_phase=1, alternating every 2 frames. Other bits are unaffected. BLINK_SEL=0 never suppresses.
- RST asserted while DIG_SEL=6'b000100 → all outputs 0 the next cycle. This is followed by an 8-cycle dead slot, then hour tens. The snapshot is cleared, so the display shows code(0) until LOAD.
- FRAME_START → exactly one 1-cycle pulse per 48 cycles, aligned with the first cycle of the hour-tens slot. It never occurs during the dead slot after reset.

Source files
------------

// File: rtl/disp_scan_ctrl_pkg.sv
// Shared constants and helpers for the multiplexed HH:MM:SS display scanner.
// Digit 0 is the leftmost (hour tens); digit 5 is the rightmost (second units).
package disp_scan_ctrl_pkg;

    localparam logic [2:0] DIG_H10 = 3'd0;
    localparam logic [2:0] DIG_H1  = 3'd1;
    localparam logic [2:0] DIG_M10 = 3'd2;
    localparam logic [2:0] DIG_M1  = 3'd3;
    localparam logic [2:0] DIG_S10 = 3'd4;
    localparam logic [2:0] DIG_S1  = 3'd5;

    typedef enum logic [1:0] {
        FLD_HOUR = 2'd0,
        FLD_MIN  = 2'd1,
        FLD_SEC  = 2'd2
    } field_e;

    typedef enum logic [1:0] {
        BLINK_NONE = 2'd0,
        BLINK_HOUR = 2'd1,
        BLINK_MIN  = 2'd2,
        BLINK_SEC  = 2'd3
    } blink_sel_e;

    // Active-high segments, bit order {dp,g,f,e,d,c,b,a}
    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] code;
        case (d)
            4'd0:    code = 8'h3F;
            4'd1:    code = 8'h06;
            4'd2:    code = 8'h5B;
            4'd3:    code = 8'h4F;
            4'd4:    code = 8'h66;
            4'd5:    code = 8'h6D;
            4'd6:    code = 8'h7D;
            4'd7:    code = 8'h07;
            4'd8:    code = 8'h7F;
            4'd9:    code = 8'h6F;
            default: code = 8'h00;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] dig_field(input logic [2:0] d);
        logic [1:0] f;
        case (d)
            DIG_H10, DIG_H1: f = FLD_HOUR;
            DIG_M10, DIG_M1: f = FLD_MIN;
            DIG_S10, DIG_S1: f = FLD_SEC;
            default:         f = FLD_HOUR;
        endcase
        return f;
    endfunction

    function automatic logic [5:0] dig_onehot(input logic [2:0] d);
        logic [5:0] oh;
        case (d)
            DIG_H10: oh = 6'b100000;
            DIG_H1:  oh = 6'b010000;
            DIG_M10: oh = 6'b001000;
            DIG_M1:  oh = 6'b000100;
            DIG_S10: oh = 6'b000010;
            DIG_S1:  oh = 6'b000001;
            default: oh = 6'b000000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_clock_sep.sv
// Splits a 0..99 value into tens/units segment codes; out-of-range values
// show as zero on both digits.
module disp_scan_ctrl_clock_sep
    import disp_scan_ctrl_pkg::*;
(
    input  logic [6:0] NUMBER,
    output logic [7:0] N10,
    output logic [7:0] N1
);

    logic [3:0] tens_s;
    logic [3:0] units_s;

    // Decimal split and segment encoding
    always_comb begin
        if (NUMBER > 7'd99) begin
            tens_s  = 4'd0;
            units_s = 4'd0;
        end else begin
            tens_s  = 4'(NUMBER / 7'd10);
            units_s = 4'(NUMBER % 7'd10);
        end
        N10 = seg_code(tens_s);
        N1  = seg_code(units_s);
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Six-digit HH:MM:SS scan controller: snapshot, slot prescaler, digit
// sequencer with anti-ghost blanking and set-mode field blinking.
module disp_scan_ctrl
    import disp_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] HOUR,
    input  logic [6:0] MIN,
    input  logic [6:0] SEC,
    input  logic       LOAD,
    input  logic [1:0] BLINK_SEL,
    output logic [7:0] SEG_DATA,
    output logic [5:0] DIG_SEL,
    output logic       FRAME_START
);

    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_EN    = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);
    localparam bit                HAS_BLANK = (BLANK_CYC > 0);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        dig_q, dig_d;
    logic              primed_q, primed_d;
    logic [6:0]        snap_hour_q, snap_hour_d;
    logic [6:0]        snap_min_q, snap_min_d;
    logic [6:0]        snap_sec_q, snap_sec_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              blink_phase_q, blink_phase_d;
    logic [7:0]        seg_q, seg_d;
    logic [5:0]        dig_sel_q, dig_sel_d;
    logic              frame_start_q, frame_start_d;

    logic       wrap_s;
    logic       en_edge_s;
    logic       frame_s;
    logic [2:0] next_dig_s;
    logic [6:0] num_s;
    logic [7:0] n10_s;
    logic [7:0] n1_s;
    logic [2:0] en_dig_s;
    logic       en_primed_s;
    logic       en_phase_s;
    logic       blink_hit_s;

    assign wrap_s     = (cnt_q == CNT_LAST);
    assign en_edge_s  = HAS_BLANK ? (cnt_q == CNT_EN) : wrap_s;
    assign next_dig_s = (dig_q == DIG_S1) ? DIG_H10 : dig_q + 3'd1;
    assign frame_s    = wrap_s && (dig_q == DIG_S1);

    // Converter input: the snapshot field owning the digit about to be shown
    always_comb begin
        case (dig_field(next_dig_s))
            FLD_HOUR: num_s = snap_hour_q;
            FLD_MIN:  num_s = snap_min_q;
            FLD_SEC:  num_s = snap_sec_q;
            default:  num_s = 7'd0;
        endcase
    end

    disp_scan_ctrl_clock_sep u_clock_sep (
        .NUMBER (num_s),
        .N10    (n10_s),
        .N1     (n1_s)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q         <= '0;
            dig_q         <= DIG_S1;
            primed_q      <= 1'b0;
            snap_hour_q   <= 7'd0;
            snap_min_q    <= 7'd0;
            snap_sec_q    <= 7'd0;
            fcnt_q        <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= 8'h00;
            dig_sel_q     <= 6'b000000;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            dig_q         <= dig_d;
            primed_q      <= primed_d;
            snap_hour_q   <= snap_hour_d;
            snap_min_q    <= snap_min_d;
            snap_sec_q    <= snap_sec_d;
            fcnt_q        <= fcnt_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            dig_sel_q     <= dig_sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Next state: prescaler, digit sequencer, snapshot, blink frame counter
    always_comb begin
        if (wrap_s) begin
            cnt_d    = '0;
            dig_d    = next_dig_s;
            primed_d = 1'b1;
        end else begin
            cnt_d    = cnt_q + CNT_W'(1);
            dig_d    = dig_q;
            primed_d = primed_q;
        end

        if (LOAD) begin
            snap_hour_d = HOUR;
            snap_min_d  = MIN;
            snap_sec_d  = SEC;
        end else begin
            snap_hour_d = snap_hour_q;
            snap_min_d  = snap_min_q;
            snap_sec_d  = snap_sec_q;
        end

        if (frame_s && (fcnt_q == FCNT_LAST)) begin
            fcnt_d        = '0;
            blink_phase_d = ~blink_phase_q;
        end else if (frame_s) begin
            fcnt_d        = fcnt_q + FCNT_W'(1);
            blink_phase_d = blink_phase_q;
        end else begin
            fcnt_d        = fcnt_q;
            blink_phase_d = blink_phase_q;
        end
    end

    // Output next values; without blanking the enable coincides with the
    // wrap, so it looks at the slot being entered rather than the current one
    always_comb begin
        if (HAS_BLANK) begin
            en_dig_s    = dig_q;
            en_primed_s = primed_q;
            en_phase_s  = blink_phase_q;
        end else begin
            en_dig_s    = next_dig_s;
            en_primed_s = 1'b1;
            en_phase_s  = blink_phase_d;
        end

        blink_hit_s = en_phase_s && (BLINK_SEL != BLINK_NONE)
                      && (dig_field(en_dig_s) == 2'(BLINK_SEL - 2'd1));

        if (wrap_s && next_dig_s[0]) begin
            seg_d = n1_s;
        end else if (wrap_s) begin
            seg_d = n10_s;
        end else begin
            seg_d = seg_q;
        end

        if (en_edge_s && en_primed_s && !blink_hit_s) begin
            dig_sel_d = dig_onehot(en_dig_s);
        end else if (en_edge_s || wrap_s) begin
            dig_sel_d = 6'b000000;
        end else begin
            dig_sel_d = dig_sel_q;
        end

        frame_start_d = frame_s;
    end

    assign SEG_DATA    = seg_q;
    assign DIG_SEL     = dig_sel_q;
    assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized bench for disp_scan_ctrl with a slot/frame-arithmetic reference model.
module tb_disp_scan_ctrl;

    localparam int SD   = 8;
    localparam int BC   = 2;
    localparam int BF   = 2;
    localparam int MAXK = 4096;

    logic       CLK = 1'b0;
    logic       RST;
    logic [6:0] HOUR, MIN, SEC;
    logic       LOAD;
    logic [1:0] BLINK_SEL;
    logic [7:0] SEG_DATA;
    logic [5:0] DIG_SEL;
    logic       FRAME_START;

    always #5 CLK = ~CLK;

    disp_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .HOUR        (HOUR),
        .MIN         (MIN),
        .SEC         (SEC),
        .LOAD        (LOAD),
        .BLINK_SEL   (BLINK_SEL),
        .SEG_DATA    (SEG_DATA),
        .DIG_SEL     (DIG_SEL),
        .FRAME_START (FRAME_START)
    );

    int n_checks = 0;
    int n_errors = 0;
    int k = 0;          // clock edges since the last reset edge
    bit started = 1'b0;

    // Snapshot contents and BLINK_SEL as seen at each edge since reset
    logic [6:0] sh [MAXK];
    logic [6:0] sm [MAXK];
    logic [6:0] ss [MAXK];
    logic [1:0] bs [MAXK];

    logic [7:0] exp_seg;
    logic [5:0] exp_dig;
    logic       exp_fs;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at k=%0d: got %h expected %h", tag, k, got, exp);
        end
    endtask

    function automatic logic [7:0] seg_of(input int n);
        case (n)
            0: return 8'h3F;
            1: return 8'h06;
            2: return 8'h5B;
            3: return 8'h4F;
            4: return 8'h66;
            5: return 8'h6D;
            6: return 8'h7D;
            7: return 8'h07;
            8: return 8'h7F;
            9: return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int digit_val(input int v, input bit tens);
        if (v > 99) return 0;
        return tens ? v / 10 : v % 10;
    endfunction

    // Expected outputs after kk edges: slot 0 is dead, slots then walk digits 0..5
    task automatic model(input int kk);
        int s, p, d, k0, ke, f, v;
        bit phase, supp;
        s = kk / SD;
        p = kk % SD;
        if (s == 0) begin
            exp_seg = 8'h00;
            exp_dig = 6'b000000;
            exp_fs  = 1'b0;
        end else begin
            d  = (s - 1) % 6;
            k0 = s * SD;
            case (d / 2)
                0:       v = int'(sh[k0-1]);
                1:       v = int'(sm[k0-1]);
                default: v = int'(ss[k0-1]);
            endcase
            exp_seg = seg_of(digit_val(v, (d % 2) == 0));
            f     = (s - 1) / 6 + 1;
            phase = ((f / BF) % 2) == 1;
            ke    = k0 + BC;
            supp  = 1'b0;
            if (p >= BC)
                supp = phase && (bs[ke] != 2'd0) && ((d / 2) == int'(bs[ke]) - 1);
            if (p >= BC && !supp)
                exp_dig = 6'(32 >> d);
            else
                exp_dig = 6'b000000;
            exp_fs = (p == 0) && (d == 0);
        end
    endtask

    // load_mode: 0 none, 1 random, 2 load current HOUR/MIN/SEC
    task automatic do_cycle(input bit rst_v, input int load_mode, input bit rnd_blink);
        @(negedge CLK);
        if (started) begin
            model(k);
            check_val("seg_data", 32'(SEG_DATA), 32'(exp_seg));
            check_val("dig_sel", 32'(DIG_SEL), 32'(exp_dig));
            check_val("frame_start", 32'(FRAME_START), 32'(exp_fs));
        end
        RST  = rst_v;
        LOAD = 1'b0;
        if (load_mode == 2) begin
            LOAD = 1'b1;
        end else if (load_mode == 1 && $urandom_range(0, 15) == 0) begin
            LOAD = 1'b1;
            HOUR = 7'($urandom_range(0, 127));
            MIN  = 7'($urandom_range(0, 127));
            SEC  = 7'($urandom_range(0, 127));
        end
        if (rnd_blink && $urandom_range(0, 39) == 0)
            BLINK_SEL = 2'($urandom_range(0, 3));
        @(posedge CLK);
        if (rst_v) begin
            k = 0;
            sh[0] = 7'd0; sm[0] = 7'd0; ss[0] = 7'd0; bs[0] = BLINK_SEL;
            started = 1'b1;
        end else if (started) begin
            k++;
            if (k >= MAXK) begin
                $display("FAIL model_range: k=%0d exceeds %0d", k, MAXK - 1);
                $fatal(1, "model history overflow");
            end
            bs[k] = BLINK_SEL;
            sh[k] = LOAD ? HOUR : sh[k-1];
            sm[k] = LOAD ? MIN  : sm[k-1];
            ss[k] = LOAD ? SEC  : ss[k-1];
        end
    endtask

    initial begin
        bit found;
        RST = 1'b1; LOAD = 1'b0; BLINK_SEL = 2'd0;
        HOUR = 7'd0; MIN = 7'd0; SEC = 7'd0;
        repeat (2) do_cycle(1'b1, 0, 1'b0);

        HOUR = 7'd12; MIN = 7'd34; SEC = 7'd56;
        do_cycle(1'b0, 2, 1'b0);
        repeat (100) do_cycle(1'b0, 0, 1'b0);

        HOUR = 7'd100; MIN = 7'd7; SEC = 7'd0;
        do_cycle(1'b0, 2, 1'b0);
        repeat (60) do_cycle(1'b0, 0, 1'b0);

        HOUR = 7'd23; MIN = 7'd48; SEC = 7'd7;
        BLINK_SEL = 2'd2;
        do_cycle(1'b0, 2, 1'b0);
        repeat (300) do_cycle(1'b0, 0, 1'b0);

        repeat (1500) do_cycle(1'b0, 1, 1'b1);

        // Reset while minute units is lit
        BLINK_SEL = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            model(k);
            if (exp_dig == 6'b000100) begin
                found = 1'b1;
                do_cycle(1'b1, 0, 1'b0);
            end else begin
                do_cycle(1'b0, 0, 1'b0);
            end
        end
        check_val("reset_hunt", 32'(found), 32'd1);

        repeat (120) do_cycle(1'b0, 0, 1'b0);
        repeat (800) do_cycle(1'b0, 1, 1'b1);
        do_cycle(1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
